// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed single-port synchronous RAM.
// Serves one read or write transaction at a time, INCR bursts up to 16 beats of 4 bytes.
module axi_sram_slave #(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_WR    = 2'd2,
    S_WRESP = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  len_r;
  logic [29:0] ptr_r;
  logic [4:0]  cnt_r;
  logic        err_r;
  logic [31:0] mem_r [MEM_WORDS];
  logic [31:0] ram_q_r;
  logic        q_vld_r;
  logic        q_err_r;
  logic        q_last_r;

  logic ar_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic ptr_oor_s;
  logic out_free_s;
  logic q_adv_s;
  logic issue_s;
  logic w_cnt_last_s;
  logic w_end_s;
  logic w_bad_s;
  logic mem_we_s;
  logic unused_s;

  function automatic logic out_of_range(input logic [29:0] p);
    return (p[29:ADDR_W] != {(30-ADDR_W){1'b0}});
  endfunction

  assign arready      = (state_r == S_IDLE) & ~reset;
  assign awready      = (state_r == S_IDLE) & ~arvalid & ~reset;
  assign wready       = (state_r == S_WR) & ~reset;
  assign ar_hs_s      = arvalid & arready;
  assign aw_hs_s      = awvalid & awready;
  assign w_hs_s       = wvalid & wready;
  assign ptr_oor_s    = out_of_range(ptr_r);
  // Two-stage read pipe: RAM output register feeds the R output register.
  assign out_free_s   = ~rvalid | rready;
  assign q_adv_s      = ~q_vld_r | out_free_s;
  assign issue_s      = (state_r == S_RD) & q_adv_s & (cnt_r <= {1'b0, len_r});
  // A burst whose wlast disagrees with the beat count ends early and reports SLVERR.
  assign w_cnt_last_s = (cnt_r[3:0] == len_r);
  assign w_end_s      = wlast | w_cnt_last_s;
  assign w_bad_s      = (wlast ^ w_cnt_last_s) | ptr_oor_s | err_r;
  assign mem_we_s     = w_hs_s & ~ptr_oor_s;
  assign unused_s     = ^{arlen[7:4], araddr[1:0], arsize, arburst, arlock, arcache, arprot,
                          awlen[7:4], awaddr[1:0], awsize, awburst, awlock, awcache, awprot, wid};

  // RAM port: byte-enabled writes during WR, registered read feeding the R pipe.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem_r[ptr_r[ADDR_W-1:0]][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (issue_s) begin
      ram_q_r <= mem_r[ptr_r[ADDR_W-1:0]];
    end
  end

  // Transaction FSM with registered R/B channel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      len_r    <= 4'd0;
      ptr_r    <= 30'd0;
      cnt_r    <= 5'd0;
      err_r    <= 1'b0;
      q_vld_r  <= 1'b0;
      q_err_r  <= 1'b0;
      q_last_r <= 1'b0;
      rid      <= 4'd0;
      rdata    <= 32'd0;
      rresp    <= 2'b00;
      rlast    <= 1'b0;
      rvalid   <= 1'b0;
      bid      <= 4'd0;
      bresp    <= 2'b00;
      bvalid   <= 1'b0;
    end else begin
      if (out_free_s) begin
        rvalid <= q_vld_r;
        if (q_vld_r) begin
          rdata <= q_err_r ? 32'd0 : ram_q_r;
          rresp <= q_err_r ? 2'b10 : 2'b00;
          rlast <= q_last_r;
        end
      end
      if (q_adv_s) begin
        q_vld_r <= issue_s;
      end
      case (state_r)
        S_IDLE: begin
          if (ar_hs_s) begin
            rid     <= arid;
            len_r   <= arlen[3:0];
            ptr_r   <= araddr[31:2];
            cnt_r   <= 5'd0;
            state_r <= S_RD;
          end else if (aw_hs_s) begin
            bid     <= awid;
            len_r   <= awlen[3:0];
            ptr_r   <= awaddr[31:2];
            cnt_r   <= 5'd0;
            err_r   <= 1'b0;
            state_r <= S_WR;
          end
        end
        S_RD: begin
          if (issue_s) begin
            q_err_r  <= ptr_oor_s;
            q_last_r <= (cnt_r[3:0] == len_r);
            ptr_r    <= ptr_r + 30'd1;
            cnt_r    <= cnt_r + 5'd1;
          end
          if (rvalid & rready & rlast) begin
            state_r <= S_IDLE;
          end
        end
        S_WR: begin
          if (w_hs_s) begin
            ptr_r <= ptr_r + 30'd1;
            cnt_r <= cnt_r + 5'd1;
            err_r <= err_r | ptr_oor_s;
            if (w_end_s) begin
              bvalid  <= 1'b1;
              bresp   <= w_bad_s ? 2'b10 : 2'b00;
              state_r <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bvalid & bready) begin
            bvalid  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
